// File: rtl/freq_pkg.sv
// Shared frequency-path definitions: autorange FSM encoding and the default
// gate/threshold values used by the counting, autorange and display blocks.
package freq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      EVAL  = 2'd3
   } state_t;

   localparam int DEF_BASE_PERIOD = 1199;
   localparam int DEF_LOW         = 10;
   localparam int DEF_HIGH        = 99;

endpackage

// File: rtl/freq_autorange_if.sv
// Handshake between the autorange controller (master) and the counting engine (slave).
interface freq_autorange_if #(
   parameter int BITS     = 12,
   parameter int CNT_BITS = 8
);
   logic                meas_start;
   logic [BITS-1:0]     meas_period;
   logic                meas_done;
   logic [CNT_BITS-1:0] meas_count;
   logic                meas_ovf;

   modport master (
      output meas_start,
      output meas_period,
      input  meas_done,
      input  meas_count,
      input  meas_ovf
   );

   modport slave (
      input  meas_start,
      input  meas_period,
      output meas_done,
      output meas_count,
      output meas_ovf
   );
endinterface

// File: rtl/autorange_period_rom.sv
// Range index to gate period: period(k) = ((BASE_PERIOD+1) >> k) - 1.
// Indices beyond RANGES-1 alias the shortest window.
module autorange_period_rom #(
   parameter int BITS        = 12,
   parameter int BASE_PERIOD = 1199,
   parameter int RANGES      = 4
) (
   input  logic [2:0]      range_idx,
   output logic [BITS-1:0] period
);

   logic [BITS-1:0] table_w [8];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_entry
         localparam int K = (gi < RANGES) ? gi : RANGES - 1;
         localparam int P = ((BASE_PERIOD + 1) >> K) - 1;
         assign table_w[gi] = BITS'(P);
      end
   endgenerate

   assign period = table_w[range_idx];

endmodule

// File: rtl/freq_autorange.sv
// Autoranging controller: steps the gate window of the counting engine until
// the edge count lands in LOW..HIGH, then publishes the count and range.
module freq_autorange
   import freq_pkg::*;
#(
   parameter int BITS        = 12,
   parameter int BASE_PERIOD = DEF_BASE_PERIOD,
   parameter int RANGES      = 4,
   parameter int CNT_BITS    = 8,
   parameter int LOW         = DEF_LOW,
   parameter int HIGH        = DEF_HIGH,
   parameter int TIMEOUT     = 2047
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   freq_autorange_if.master    meas,
   output logic                result_valid,
   output logic [CNT_BITS-1:0] result_count,
   output logic [2:0]          result_range,
   output logic                result_ovf,
   output logic                busy,
   output logic                timeout_err
);

   localparam logic [2:0]          TOP_RANGE = 3'(RANGES - 1);
   localparam logic [CNT_BITS-1:0] LOW_CNT   = CNT_BITS'(LOW);
   localparam logic [CNT_BITS-1:0] HIGH_CNT  = CNT_BITS'(HIGH);
   localparam logic [BITS-1:0]     TMO_LAST  = BITS'(TIMEOUT - 1);
   localparam logic [BITS-1:0]     PERIOD0   = BITS'(BASE_PERIOD);

   state_t              state_reg;
   logic [2:0]          range_reg;
   logic [BITS-1:0]     tmo_cnt_reg;
   logic                start_reg;
   logic [BITS-1:0]     period_reg;
   logic                valid_reg;
   logic [CNT_BITS-1:0] count_reg;
   logic [2:0]          res_range_reg;
   logic                res_ovf_reg;
   logic                busy_reg;
   logic                tmo_err_reg;

   logic [BITS-1:0]     rom_period;
   logic                step_up;
   logic                step_down;
   logic                accept;
   logic [2:0]          range_next;

   autorange_period_rom #(
      .BITS        (BITS),
      .BASE_PERIOD (BASE_PERIOD),
      .RANGES      (RANGES)
   ) u_rom (
      .range_idx (range_reg),
      .period    (rom_period)
   );

   // The decision is taken on the engine's count as meas_done is sampled, so the
   // result registers and the new range are already valid during EVAL.
   always_comb begin
      step_up    = (meas.meas_ovf || (meas.meas_count > HIGH_CNT)) && (range_reg < TOP_RANGE);
      step_down  = !step_up && (meas.meas_count < LOW_CNT) && (range_reg != 3'd0);
      accept     = !step_up && !step_down;
      range_next = range_reg;
      if (step_up) begin
         range_next = range_reg + 3'd1;
      end else if (step_down) begin
         range_next = range_reg - 3'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         range_reg     <= 3'd0;
         tmo_cnt_reg   <= '0;
         start_reg     <= 1'b0;
         period_reg    <= PERIOD0;
         valid_reg     <= 1'b0;
         count_reg     <= '0;
         res_range_reg <= 3'd0;
         res_ovf_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         tmo_err_reg   <= 1'b0;
      end else begin
         start_reg <= 1'b0;
         valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (enable) begin
                  state_reg  <= START;
                  start_reg  <= 1'b1;
                  period_reg <= rom_period;
                  busy_reg   <= 1'b1;
               end
            end
            START: begin
               tmo_cnt_reg <= '0;
               state_reg   <= WAIT;
            end
            WAIT: begin
               if (meas.meas_done) begin
                  state_reg <= EVAL;
                  range_reg <= range_next;
                  if (accept) begin
                     valid_reg     <= 1'b1;
                     count_reg     <= meas.meas_count;
                     res_range_reg <= range_reg;
                     res_ovf_reg   <= meas.meas_ovf && (range_reg == TOP_RANGE);
                  end
               end else if (tmo_cnt_reg == TMO_LAST) begin
                  // Engine never answered: retry the same window without a result.
                  tmo_err_reg <= 1'b1;
                  state_reg   <= START;
                  start_reg   <= 1'b1;
                  period_reg  <= rom_period;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end
            EVAL: begin
               if (enable) begin
                  state_reg  <= START;
                  start_reg  <= 1'b1;
                  period_reg <= rom_period;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign meas.meas_start  = start_reg;
   assign meas.meas_period = period_reg;
   assign result_valid     = valid_reg;
   assign result_count     = count_reg;
   assign result_range     = res_range_reg;
   assign result_ovf       = res_ovf_reg;
   assign busy             = busy_reg;
   assign timeout_err      = tmo_err_reg;

endmodule

// File: tb/tb_freq_autorange.sv
// Directed and randomized check of freq_autorange against a behavioural
// engine and range-selection model.
module tb_freq_autorange;

   localparam int BASE    = 1199;
   localparam int RANGES  = 4;
   localparam int LOW     = 10;
   localparam int HIGH    = 99;
   localparam int TIMEOUT = 2047;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       result_valid;
   logic [7:0] result_count;
   logic [2:0] result_range;
   logic       result_ovf;
   logic       busy;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   int m_range      = 0;
   int m_last_count = 0;
   int m_last_range = 0;
   bit m_last_ovf   = 0;

   freq_autorange_if #(.BITS(12), .CNT_BITS(8)) meas_bus ();

   freq_autorange dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .meas         (meas_bus),
      .result_valid (result_valid),
      .result_count (result_count),
      .result_range (result_range),
      .result_ovf   (result_ovf),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   function automatic int model_period(input int k);
      return ((BASE + 1) >> k) - 1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_start;
      int n = 0;
      while (meas_bus.meas_start !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("start_seen", 32'(meas_bus.meas_start), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start"},   32'(meas_bus.meas_start),  0);
      check({tag, "_period"},  32'(meas_bus.meas_period), model_period(0));
      check({tag, "_valid"},   32'(result_valid),         0);
      check({tag, "_count"},   32'(result_count),         0);
      check({tag, "_range"},   32'(result_range),         0);
      check({tag, "_rovf"},    32'(result_ovf),           0);
      check({tag, "_busy"},    32'(busy),                 0);
      check({tag, "_tmo_err"}, 32'(timeout_err),          0);
   endtask

   // One full measurement: start, engine delay, done, evaluation, next start.
   task automatic measure(input int cnt, input bit ovf, input int dly, input bit drop_en);
      bit exp_acc;
      bit exp_rovf;
      int r_before;
      wait_start();
      r_before = m_range;
      check("period", 32'(meas_bus.meas_period), model_period(m_range));
      // A done pulse during START must be ignored.
      meas_bus.meas_done  = 1'b1;
      meas_bus.meas_count = 8'd5;
      meas_bus.meas_ovf   = 1'b0;
      tick();
      meas_bus.meas_done = 1'b0;
      check("start_len", 32'(meas_bus.meas_start), 0);
      check("busy_wait", 32'(busy), 1);
      repeat (dly) tick();
      if (drop_en) enable = 1'b0;
      meas_bus.meas_done  = 1'b1;
      meas_bus.meas_count = 8'(cnt);
      meas_bus.meas_ovf   = ovf;
      tick();
      meas_bus.meas_done  = 1'b0;
      meas_bus.meas_count = 8'($urandom_range(0, 255));
      meas_bus.meas_ovf   = 1'($urandom_range(0, 1));

      exp_rovf = 1'b0;
      if ((ovf || cnt > HIGH) && m_range < RANGES - 1) begin
         m_range = m_range + 1;
         exp_acc = 1'b0;
      end else if (cnt < LOW && m_range > 0) begin
         m_range = m_range - 1;
         exp_acc = 1'b0;
      end else begin
         exp_acc      = 1'b1;
         exp_rovf     = ovf && (m_range == RANGES - 1);
         m_last_count = cnt;
         m_last_range = m_range;
         m_last_ovf   = exp_rovf;
      end

      check("result_valid", 32'(result_valid), 32'(exp_acc));
      check("result_count", 32'(result_count), m_last_count);
      check("result_range", 32'(result_range), m_last_range);
      check("result_ovf",   32'(result_ovf),   32'(m_last_ovf));
      tick();
      check("next_start", 32'(meas_bus.meas_start), 32'(!drop_en));
      check("busy_after", 32'(busy), 32'(!drop_en));
      if (!drop_en)
         check("next_period", 32'(meas_bus.meas_period), model_period(m_range));
      $display("meas range=%0d count=%0d ovf=%0b dly=%0d accept=%0b new_range=%0d",
               r_before, cnt, ovf, dly, exp_acc, m_range);
   endtask

   initial begin
      int seen;
      int p;
      reset               = 1'b1;
      enable              = 1'b0;
      meas_bus.meas_done  = 1'b0;
      meas_bus.meas_count = 8'd0;
      meas_bus.meas_ovf   = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");
      reset = 1'b0;
      tick();
      check("idle_no_start", 32'(meas_bus.meas_start), 0);
      check("idle_busy", 32'(busy), 0);

      // enable from IDLE: start pulse follows one clock later
      enable = 1'b1;
      check("en_not_yet", 32'(meas_bus.meas_start), 0);
      tick();
      check("en_start", 32'(meas_bus.meas_start), 1);

      measure(50, 0, 3, 0);
      measure(255, 1, 2, 0);
      measure(75, 0, 1, 0);
      measure(255, 1, 0, 0);
      measure(255, 1, 4, 0);
      measure(255, 1, 2, 0);
      measure(5, 0, 1, 0);
      measure(5, 0, 3, 0);
      measure(40, 0, 2, 0);
      measure(LOW, 0, 1, 0);
      measure(HIGH, 0, 0, 0);
      measure(HIGH + 1, 0, 2, 0);
      measure(LOW - 1, 0, 1, 0);
      measure(3, 0, 1, 0);
      measure(3, 0, 2, 0);

      for (int i = 0; i < 40; i++) begin
         int c;
         bit o;
         c = (i % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 120);
         o = ($urandom_range(0, 7) == 0);
         measure(c, o, $urandom_range(0, 6), 0);
      end

      // Timeout: withhold done for TIMEOUT wait cycles.
      wait_start();
      p = model_period(m_range);
      check("tmo_period", 32'(meas_bus.meas_period), p);
      seen = 0;
      tick();
      for (int i = 1; i < TIMEOUT; i++) begin
         if (result_valid || meas_bus.meas_start) seen++;
         tick();
      end
      if (result_valid || meas_bus.meas_start) seen++;
      check("tmo_quiet", seen, 0);
      check("tmo_not_yet", 32'(timeout_err), 0);
      tick();
      check("tmo_err", 32'(timeout_err), 1);
      check("tmo_restart", 32'(meas_bus.meas_start), 1);
      check("tmo_same_period", 32'(meas_bus.meas_period), p);
      check("tmo_no_result", 32'(result_valid), 0);
      $display("timeout range=%0d period=%0d", m_range, p);
      measure(50, 0, 2, 0);
      check("tmo_sticky", 32'(timeout_err), 1);

      // enable dropped mid-WAIT: result still published, then idle.
      measure(60, 0, 2, 1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (meas_bus.meas_start) seen++;
         tick();
      end
      check("drop_no_start", seen, 0);
      check("drop_idle", 32'(busy), 0);

      // Reach range 2, then reset asynchronously mid-WAIT.
      enable = 1'b1;
      for (int i = 0; i < 8 && m_range < 2; i++) measure(255, 1, 1, 0);
      for (int i = 0; i < 8 && m_range > 2; i++) measure(0, 0, 1, 0);
      check("at_range2", m_range, 2);
      wait_start();
      check("r2_period", 32'(meas_bus.meas_period), model_period(2));
      tick();
      tick();
      reset = 1'b1;
      #2;
      check_reset_outputs("async_rst");
      $display("async reset mid-wait at range 2");
      reset        = 1'b0;
      m_range      = 0;
      m_last_count = 0;
      m_last_range = 0;
      m_last_ovf   = 0;
      tick();
      measure(50, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
